// File: rtl/descaler.sv
// -----------------------------------------------------------------------------
// descaler
//   Receive-side inverse of the block scaler. Each block starts with a header
//   word whose low SCALE_BITWIDTH bits carry the block peak magnitude (scale),
//   followed by BLOCK_SIZE-1 quantised IQ words. Every quantised component is
//   restored to 16-bit amplitude as q*scale/2^(QUANTISATION_BITWIDTH-1),
//   saturated to [-32767, +32767].
//
//   Two-stage pipeline (multiply, then shift/saturate) that stalls as a whole:
//   inReady = !outValid || outReady. Headers are consumed and never forwarded.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   syncTo10ms    block resync pulse; the word accepted in the same cycle is a header
//   inData        header or quantised sample word {Q[31:16], I[15:0]}
//   inValid       inData valid
//   inReady       descaler can accept inData
//   outData       restored sample {Q, I}, signed 16-bit each
//   outValid      outData valid
//   outReady      sink accepts outData
//   outSof        marks the first sample of each block (valid with outValid)
//   currentScale  scale of the block being received
//
// Build option
//   DESCALER_ROUND_EN  defined: round half away from zero before the shift.
//                      undefined: plain arithmetic shift (floor).
// -----------------------------------------------------------------------------
module descaler #(
  parameter int INPUT_DATA_BITWIDTH   = 32,
  parameter int QUANTISATION_BITWIDTH = 12,
  parameter int SCALE_BITWIDTH        = 16,
  parameter int BLOCK_SIZE            = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           syncTo10ms,
  input  logic [INPUT_DATA_BITWIDTH-1:0] inData,
  input  logic                           inValid,
  output logic                           inReady,
  output logic [INPUT_DATA_BITWIDTH-1:0] outData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic                           outSof,
  output logic [SCALE_BITWIDTH-1:0]      currentScale
);

  localparam int QB = QUANTISATION_BITWIDTH;
  localparam int HW = INPUT_DATA_BITWIDTH / 2;
  // signed QB-bit sample times zero-extended (signed SCALE_BITWIDTH+1) scale
  localparam int PW = QB + SCALE_BITWIDTH + 1;
  localparam int CW = $clog2(BLOCK_SIZE);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_SIZE - 1);

  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (HW - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;

`ifdef DESCALER_ROUND_EN
  // Half-LSB bias. Negative products get one less so that the flooring shift
  // still rounds exact halves away from zero and everything else to nearest.
  localparam logic signed [PW-1:0] RND_POS = PW'(2 ** (QB - 2));
  localparam logic signed [PW-1:0] RND_NEG = PW'((2 ** (QB - 2)) - 1);
`endif

  typedef enum logic [0:0] {
    WAIT_HDR = 1'b0,
    DATA     = 1'b1
  } stateT;

  stateT                 state;
  logic [CW-1:0]         counter;

  logic                  advance;
  logic                  accept;
  logic                  isSample;
  logic                  firstSample;
  logic signed [PW-1:0]  sampI;
  logic signed [PW-1:0]  sampQ;
  logic signed [PW-1:0]  scaleExt;
  logic signed [PW-1:0]  prodI;
  logic signed [PW-1:0]  prodQ;

  logic                  s1Valid;
  logic                  s1Sof;
  logic signed [PW-1:0]  s1ProdI;
  logic signed [PW-1:0]  s1ProdQ;

  // Top nibble of the Q half is never looked at.
  logic                  unusedBits;
  assign unusedBits = ^inData[2*HW-1:HW+QB];

  // Shift down by QB-1 (optionally rounded) and clip to the symmetric 16-bit range.
  function automatic logic [HW-1:0] descaleComp(input logic signed [PW-1:0] prod);
    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] shifted;
    logic [HW-1:0]        result;
`ifdef DESCALER_ROUND_EN
    if (prod[PW-1]) begin
      biased = prod + RND_NEG;
    end else begin
      biased = prod + RND_POS;
    end
`else
    biased = prod;
`endif
    shifted = biased >>> (QB - 1);
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[HW-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[HW-1:0];
    end else begin
      result = shifted[HW-1:0];
    end
    return result;
  endfunction

  // The whole pipeline moves together, so input readiness only depends on the output slot.
  assign advance = !outValid || outReady;
  assign inReady = advance;
  assign accept  = inValid && inReady;

  // Stage-1 operands: sign-extended quantised halves, zero-extended scale of this block.
  always_comb begin
    sampI       = {{(PW-QB){inData[QB-1]}}, inData[QB-1:0]};
    sampQ       = {{(PW-QB){inData[HW+QB-1]}}, inData[HW+QB-1:HW]};
    scaleExt    = {{(PW-SCALE_BITWIDTH){1'b0}}, currentScale};
    prodI       = sampI * scaleExt;
    prodQ       = sampQ * scaleExt;
    // A resync in the same cycle turns the accepted word into a header.
    isSample    = (state == DATA) && !syncTo10ms;
    firstSample = (counter == CNT_ONE);
  end

  // Block framing: header capture, sample counting and resync.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_HDR;
      counter      <= CNT_ZERO;
      currentScale <= {SCALE_BITWIDTH{1'b0}};
    end else if (syncTo10ms || (state == WAIT_HDR)) begin
      if (accept) begin
        currentScale <= inData[SCALE_BITWIDTH-1:0];
        counter      <= CNT_ONE;
        state        <= DATA;
      end else begin
        counter      <= CNT_ZERO;
        state        <= WAIT_HDR;
      end
    end else begin
      case (state)
        DATA: begin
          if (accept) begin
            if (counter == CNT_LAST) begin
              state   <= WAIT_HDR;
              counter <= CNT_ZERO;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
        end
        default: begin
          state   <= WAIT_HDR;
          counter <= CNT_ZERO;
        end
      endcase
    end
  end

  // Multiply stage followed by shift/saturate stage; both hold while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Sof    <= 1'b0;
      s1ProdI  <= {PW{1'b0}};
      s1ProdQ  <= {PW{1'b0}};
      outValid <= 1'b0;
      outSof   <= 1'b0;
      outData  <= {INPUT_DATA_BITWIDTH{1'b0}};
    end else if (advance) begin
      s1Valid <= accept && isSample;
      s1Sof   <= firstSample;
      if (accept && isSample) begin
        // The product already carries this block's scale, so a following
        // header cannot disturb samples still in flight.
        s1ProdI <= prodI;
        s1ProdQ <= prodQ;
      end
      outValid <= s1Valid;
      outSof   <= s1Valid && s1Sof;
      if (s1Valid) begin
        outData <= {descaleComp(s1ProdQ), descaleComp(s1ProdI)};
      end
    end
  end

endmodule

// File: tb/tb_descaler.sv
module tb_descaler;

  logic        clk = 1'b0;
  logic        rst;
  logic        syncTo10ms;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        outSof;
  logic [15:0] currentScale;

  logic        randReady = 1'b0;
  logic        manReady  = 1'b1;
  logic        rndBit    = 1'b1;

  int          nTests = 0;
  int          nFail  = 0;

  // expected / observed outputs as {sof, Q, I}
  logic [32:0] expQ[$];
  logic [32:0] gotQ[$];

  // reference model of block framing
  int          mScale   = 0;
  bit          mInBlock = 1'b0;
  int          mCount   = 0;

  descaler dut (
    .clk          (clk),
    .rst          (rst),
    .syncTo10ms   (syncTo10ms),
    .inData       (inData),
    .inValid      (inValid),
    .inReady      (inReady),
    .outData      (outData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outSof       (outSof),
    .currentScale (currentScale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rndBit <= ($urandom_range(0, 3) != 0);
  assign outReady = randReady ? rndBit : manReady;

  // every output transfer is recorded just before the edge that takes it
  always @(negedge clk) begin
    if (rst === 1'b0 && outValid === 1'b1 && outReady === 1'b1)
      gotQ.push_back({outSof, outData});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int q12(input logic [11:0] v);
    int r;
    r = {20'd0, v};
    if (r >= 2048) r = r - 4096;
    return r;
  endfunction

  // q*scale/2048 by integer arithmetic, then clipped to +-32767
  function automatic logic [15:0] refComp(input int q, input int s);
    longint p;
    longint r;
    p = longint'(q) * longint'(s);
`ifdef DESCALER_ROUND_EN
    if (p >= 0) r = (p + 1024) / 2048;
    else        r = -((-p + 1024) / 2048);
`else
    if (p >= 0) r = p / 2048;
    else        r = -((-p + 2047) / 2048);
`endif
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return r[15:0];
  endfunction

  // present one word until accepted, then update the reference model
  task automatic sendWord(input logic [31:0] w, input logic sync);
    int   waitCnt = 0;
    logic took    = 1'b0;
    inData     = w;
    inValid    = 1'b1;
    syncTo10ms = sync;
    while (!took && waitCnt < 200) begin
      @(negedge clk);
      took = inReady;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    inValid    = 1'b0;
    syncTo10ms = 1'b0;
    chk("accept", 64'(took), 64'(1'b1));
    if (took) begin
      if (sync || !mInBlock) begin
        mScale   = {16'd0, w[15:0]};
        mInBlock = 1'b1;
        mCount   = 0;
      end else begin
        expQ.push_back({(mCount == 0), refComp(q12(w[27:16]), mScale), refComp(q12(w[11:0]), mScale)});
        mCount++;
        if (mCount == 1023) mInBlock = 1'b0;
      end
    end
  endtask

  // wait for all expected outputs, then compare the stream item by item
  task automatic drain(output int sofs);
    int          budget = 0;
    logic [32:0] g;
    logic [32:0] e;
    sofs = 0;
    while (gotQ.size() < expQ.size() && budget < 5000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("outputCount", 64'(gotQ.size()), 64'(expQ.size()));
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      e = expQ.pop_front();
      chk("stream", 64'(g), 64'(e));
      if (g[32]) sofs++;
    end
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    int          sofs;
    logic [31:0] w;
    logic [31:0] holdData;
    logic        holdSof;
    logic [15:0] t3Exp;

    rst        = 1'b1;
    syncTo10ms = 1'b0;
    inValid    = 1'b0;
    inData     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rstOutData",  64'(outData),      64'(32'h0));
    chk("rstOutValid", 64'(outValid),     64'(1'b0));
    chk("rstOutSof",   64'(outSof),       64'(1'b0));
    chk("rstScale",    64'(currentScale), 64'(16'h0));
    chk("rstInReady",  64'(inReady),      64'(1'b1));

    // basic restore and two-cycle latency
    sendWord(32'h0000_4000, 1'b0);
    chk("t1Scale", 64'(currentScale), 64'(16'h4000));
    sendWord(32'hFC00_0400, 1'b0);
    chk("t1Lat1Valid", 64'(outValid), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("t1Valid", 64'(outValid), 64'(1'b1));
    chk("t1Data",  64'(outData),  64'(32'hE000_2000));
    chk("t1Sof",   64'(outSof),   64'(1'b1));
    drain(sofs);

    // full block, exactly one start-of-frame, next word is a header
    sendWord(32'h0000_7FFF, 1'b1);
    for (int i = 0; i < 1023; i++) sendWord(32'h07FF_07FF, 1'b0);
    drain(sofs);
    chk("t2Sofs", 64'(sofs), 64'(1));
    w = $urandom;
    sendWord(w, 1'b0);
    chk("t2NextHeader", 64'(currentScale), 64'(w[15:0]));

    // floor versus rounding of a half LSB
    sendWord(32'h0000_0400, 1'b1);
    sendWord(32'h0FFF_0001, 1'b0);
    @(posedge clk);
    #1;
`ifdef DESCALER_ROUND_EN
    t3Exp = 16'h0001;
`else
    t3Exp = 16'h0000;
`endif
    chk("t3Data", 64'(outData), 64'({16'hFFFF, t3Exp}));
    drain(sofs);

    // output stall: pipeline fills, holds, then releases without loss
    sendWord(32'h0000_2345, 1'b1);
    for (int i = 0; i < 3; i++) sendWord($urandom, 1'b0);
    drain(sofs);
    manReady = 1'b0;
    sendWord($urandom, 1'b0);
    sendWord($urandom, 1'b0);
    chk("t4InReady", 64'(inReady),  64'(1'b0));
    chk("t4Valid",   64'(outValid), 64'(1'b1));
    holdData = outData;
    holdSof  = outSof;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4HoldData",    64'(outData),  64'(holdData));
      chk("t4HoldSof",     64'(outSof),   64'(holdSof));
      chk("t4HoldValid",   64'(outValid), 64'(1'b1));
      chk("t4HoldInReady", 64'(inReady),  64'(1'b0));
    end
    manReady = 1'b1;
    for (int i = 0; i < 5; i++) sendWord($urandom, 1'b0);
    drain(sofs);
    chk("t4Sofs", 64'(sofs), 64'(0));

    // random scales and samples under random backpressure
    randReady = 1'b1;
    for (int b = 0; b < 4; b++) begin
      sendWord($urandom, 1'b1);
      for (int i = 0; i < 40; i++) begin
        w = $urandom;
        if (w[31:30] == 2'b01) w[11:0]  = 12'h800;
        if (w[29:28] == 2'b01) w[27:16] = 12'h800;
        sendWord(w, 1'b0);
      end
      drain(sofs);
      chk("rndSofs", 64'(sofs), 64'(1));
    end
    randReady = 1'b0;

    // resync mid-block: in-flight samples keep the old scale
    sendWord($urandom, 1'b1);
    for (int i = 0; i < 300; i++) sendWord($urandom, 1'b0);
    w = $urandom;
    w[15:0] = 16'h0000;
    sendWord(w, 1'b1);
    for (int i = 0; i < 20; i++) sendWord($urandom, 1'b0);
    drain(sofs);
    chk("t5Sofs", 64'(sofs), 64'(2));

    // largest scale with the most negative code saturates
    sendWord(32'h0000_FFFF, 1'b1);
    sendWord(32'h05A5_0800, 1'b0);
    @(posedge clk);
    #1;
    chk("t6Sat", 64'(outData[15:0]), 64'(16'h8001));
    drain(sofs);

    // reset with samples in flight flushes the pipeline and restarts framing
    manReady = 1'b0;
    sendWord($urandom, 1'b0);
    sendWord($urandom, 1'b0);
    chk("t6PreRstValid", 64'(outValid), 64'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6RstValid", 64'(outValid),     64'(1'b0));
    chk("t6RstSof",   64'(outSof),       64'(1'b0));
    chk("t6RstData",  64'(outData),      64'(32'h0));
    chk("t6RstScale", 64'(currentScale), 64'(16'h0));
    chk("t6RstNoOut", 64'(gotQ.size()),  64'(0));
    expQ.delete();
    mInBlock = 1'b0;
    mCount   = 0;
    manReady = 1'b1;
    w = $urandom;
    sendWord(w, 1'b0);
    chk("t6Header", 64'(currentScale), 64'(w[15:0]));
    for (int i = 0; i < 3; i++) sendWord($urandom, 1'b0);
    drain(sofs);
    chk("t6Sofs", 64'(sofs), 64'(1));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
